// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states and the
// alignment check used at request accept.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (size == SZ_HALF) begin
      r = addr_lo[0];
    end else if (size == SZ_WORD) begin
      r = |addr_lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian lane logic: extracts/extends a load lane from a word and merges
// sub-word store data into a word.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
  assign w_byte_sh = {~i_offset, 3'b000};
  assign w_half_sh = {~i_offset[1], 4'b0000};
  assign w_byte    = 8'(i_word >> w_byte_sh);
  assign w_half    = 16'(i_word >> w_half_sh);

  always_comb begin
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load   = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_merged = (i_word & ~(32'h0000_00FF << w_byte_sh)) |
                   (32'(i_wdata[7:0]) << w_byte_sh);
      end
      SZ_HALF: begin
        o_load   = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        o_merged = (i_word & ~(32'h0000_FFFF << w_half_sh)) |
                   (32'(i_wdata) << w_half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, drives the big-endian word
// port of the data memory, read-modify-write for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  state_e      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic [1:0]  r_offset;
  logic        r_unsigned;
  logic [31:0] r_aligned;
  logic [15:0] r_wdata;
  logic [31:0] r_rbuf;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_write;
  logic        r_mem_read;

  logic [31:0] w_aligned;
  logic        w_req_err;
  logic [31:0] w_fmt_word;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_aligned = {req_addr[31:2], 2'b00};
  assign w_req_err = (req_size == SZ_RSVD) ||
                     is_misaligned(req_size, req_addr[1:0]) ||
                     (w_aligned + 32'd3 >= 32'(MEM_BYTES));

  // Lane logic sees the live DM word during READ; rbuf holds it afterwards.
  assign w_fmt_word = (r_state == ST_READ) ? MemReadData : r_rbuf;

  mem_lane_fmt u_fmt (
    .i_word     (w_fmt_word),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_offset     <= 2'b00;
      r_unsigned   <= 1'b0;
      r_aligned    <= 32'h0;
      r_wdata      <= 16'h0;
      r_rbuf       <= 32'h0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end else begin
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_offset    <= req_addr[1:0];
            r_unsigned  <= req_unsigned;
            r_aligned   <= w_aligned;
            r_wdata     <= req_wdata[15:0];
            r_req_ready <= 1'b0;
            if (w_req_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else if (!req_write || (req_size != SZ_WORD)) begin
              r_state    <= ST_READ;
              r_mem_read <= 1'b1;
              r_mem_addr <= w_aligned;
            end else begin
              r_state     <= ST_WRITE;
              r_mem_write <= 1'b1;
              r_mem_addr  <= w_aligned;
              r_mem_wdata <= req_wdata;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_READ: begin
          r_rbuf <= MemReadData;
          if (r_write) begin
            r_state     <= ST_WRITE;
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_aligned;
            r_mem_wdata <= w_merged;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  assign MemAddr      = r_mem_addr;
  assign MemWriteData = r_mem_wdata;
  assign MemWrite     = r_mem_write;
  assign MemRead      = r_mem_read;

endmodule
